// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: one valid/ready stage with a 2-entry skid; 1 cycle in->out; in_ready never depends on out_ready.
// Stall freezes both sides and all data; flush drops contents. Define PIPE_STAGE_PERF_EN for stall/bubble counters.
module pipe_stage_skid #(
  parameter int               DATA_W         = 64,
  parameter bit               CLEAR_ON_FLUSH = 1'b1,
  parameter logic [DATA_W-1:0] RESET_DATA    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef PIPE_STAGE_PERF_EN
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_bubble_cnt
`else
  output logic [DATA_W-1:0] out_data
`endif
);

  // Occupancy encoded as a state so skid-without-main cannot be represented.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_d;
  logic              main_v;
  logic              skid_v;
  logic              in_fire;
  logic              out_fire;

  assign main_v    = (state != EMPTY);
  assign skid_v    = (state == SKID);
  assign in_ready  = !skid_v && !stall_i && !rst;
  assign out_valid = main_v && !stall_i && !rst;
  assign out_data  = main_d;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_d <= RESET_DATA;
      skid_d <= RESET_DATA;
    end else if (flush_i) begin
      // Transfers coincident with a flush are discarded on both sides.
      state <= EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d <= '0;
        skid_d <= '0;
      end
    end else if (!stall_i) begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_d <= in_data;
            state  <= FULL;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_d <= in_data;
          end else if (in_fire) begin
            skid_d <= in_data;
            state  <= SKID;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        SKID: begin
          if (out_fire) begin
            main_d <= skid_d;
            state  <= FULL;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (stall_i)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (!stall_i && !main_v)
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed vector table for pipe_stage_skid followed by a randomized scoreboard run.
module tb_pipe_stage_skid;
  localparam int         W  = 64;
  localparam logic [W-1:0] RD = 64'hDEAD_BEEF_0000_0001;

  logic         clk = 1'b0;
  logic         rst, flush_i, stall_i, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]  perf_stall_cnt, perf_bubble_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(W), .CLEAR_ON_FLUSH(1'b1), .RESET_DATA(RD)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush_i),
    .stall_i   (stall_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PIPE_STAGE_PERF_EN
    .out_data       (out_data),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`else
    .out_data  (out_data)
`endif
  );

  typedef struct {
    logic         rst, flush, stall, iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         e_ir, e_ov;
    logic [W-1:0] e_od;
  } vec_t;

  vec_t         vt[$];
  int           n_chk = 0;
  int           n_fail = 0;
  logic [W-1:0] q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic s, input logic iv,
                     input logic [W-1:0] id, input logic ordy,
                     input logic e_ir, input logic e_ov, input logic [W-1:0] e_od);
    vec_t v;
    v.rst = r; v.flush = f; v.stall = s; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od;
    vt.push_back(v);
  endtask

  initial begin
    logic         prev_hold;
    logic [W-1:0] prev_od;
    logic         f, s, iv, ordy;
    logic [W-1:0] id, exp_d;

    // Expected outputs are sampled before the clock edge that commits each row.
    //   rst f s iv data         ordy  ir ov data
    add(1, 0, 0, 1, 64'h99,      1,    0, 0, RD);     // 0 reset
    add(1, 0, 0, 1, 64'h99,      1,    0, 0, RD);     // 1 reset
    add(0, 0, 0, 0, 64'h0,       1,    1, 0, RD);     // 2 first cycle after release
    add(0, 0, 0, 1, 64'h1,       1,    1, 0, RD);     // 3 stream start
    for (int k = 2; k <= 8; k++)
      add(0, 0, 0, 1, W'(k),     1,    1, 1, W'(k - 1)); // 4..10 one beat behind
    add(0, 0, 0, 0, 64'h0,       1,    1, 1, 64'h8);  // 11 last beat out
    add(0, 0, 0, 0, 64'h0,       0,    1, 0, 64'h8);  // 12 empty, data held
    add(0, 0, 0, 1, 64'hA,       0,    1, 0, 64'h8);  // 13 push A
    add(0, 0, 0, 1, 64'hB,       0,    1, 1, 64'hA);  // 14 push B into skid
    add(0, 0, 0, 1, 64'hC,       0,    0, 1, 64'hA);  // 15 full: C refused
    add(0, 0, 0, 0, 64'h0,       1,    0, 1, 64'hA);  // 16 A out
    add(0, 0, 0, 0, 64'h0,       1,    1, 1, 64'hB);  // 17 B out, ready again
    add(0, 0, 0, 1, 64'hA,       0,    1, 0, 64'hB);  // 18 refill A
    add(0, 0, 0, 1, 64'hB,       0,    1, 1, 64'hA);  // 19 refill B
    add(0, 1, 0, 1, 64'hC,       1,    0, 1, 64'hA);  // 20 flush in SKID
    add(0, 0, 0, 0, 64'h0,       1,    1, 0, 64'h0);  // 21 flushed and cleared
    add(0, 0, 0, 1, 64'h11,      0,    1, 0, 64'h0);  // 22 push 11
    add(0, 1, 0, 1, 64'h12,      1,    1, 1, 64'h11); // 23 flush with both fires
    add(0, 0, 0, 0, 64'h0,       1,    1, 0, 64'h0);  // 24 both discarded
    add(0, 0, 0, 1, 64'h55,      1,    1, 0, 64'h0);  // 25 push 55
    for (int k = 0; k < 4; k++)
      add(0, 0, 1, 1, 64'h66,    1,    0, 0, 64'h55); // 26..29 stalled
    add(0, 0, 0, 0, 64'h0,       1,    1, 1, 64'h55); // 30 55 released
    add(0, 0, 0, 0, 64'h0,       1,    1, 0, 64'h55); // 31 empty
    add(0, 0, 0, 1, 64'h77,      0,    1, 0, 64'h55); // 32 push 77
    add(0, 0, 0, 1, 64'h78,      0,    1, 1, 64'h77); // 33 push 78 into skid
    add(0, 0, 1, 0, 64'h0,       1,    0, 0, 64'h77); // 34 stall in SKID
    add(0, 0, 0, 0, 64'h0,       1,    0, 1, 64'h77); // 35 77 out
    add(0, 0, 0, 1, 64'h79,      1,    1, 1, 64'h78); // 36 78 out, 79 in
    add(1, 0, 0, 1, 64'h7A,      1,    0, 0, 64'h79); // 37 reset mid-transfer
    add(0, 0, 0, 0, 64'h0,       1,    1, 0, RD);     // 38 contents discarded

    rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vt.size(); i++) begin
      rst = vt[i].rst; flush_i = vt[i].flush; stall_i = vt[i].stall;
      in_valid = vt[i].iv; in_data = vt[i].id; out_ready = vt[i].ordy;
      #1;
      chk($sformatf("vec%0d in_ready", i),  W'(in_ready),  W'(vt[i].e_ir));
      chk($sformatf("vec%0d out_valid", i), W'(out_valid), W'(vt[i].e_ov));
      chk($sformatf("vec%0d out_data", i),  out_data,      vt[i].e_od);
`ifdef PIPE_STAGE_PERF_EN
      if (i == 30) chk("perf_stall_cnt", W'(perf_stall_cnt), W'(32'd4));
`endif
      @(posedge clk); #1;
    end

    // Random traffic against a queue model of the stage contents.
    rst = 1'b0;
    prev_hold = 1'b0;
    prev_od = '0;
    for (int c = 0; c < 10000; c++) begin
      f    = ($urandom_range(0, 63) == 0);
      s    = ($urandom_range(0, 7) == 0);
      iv   = $urandom_range(0, 1) == 1;
      ordy = $urandom_range(0, 3) != 0;
      id   = {$urandom, $urandom};
      flush_i = f; stall_i = s; in_valid = iv; in_data = id; out_ready = ordy;
      #1;
      if (prev_hold) chk("hold out_data", out_data, prev_od);
      chk("rand in_ready",  W'(in_ready),  W'((q.size() < 2) && !s));
      chk("rand out_valid", W'(out_valid), W'((q.size() > 0) && !s));
      if (f) begin
        q.delete();
      end else begin
        if (out_valid && ordy) begin
          if (q.size() == 0) begin
            chk("rand unexpected beat", out_data, '0);
            n_fail += (out_data === '0) ? 1 : 0;
          end else begin
            exp_d = q.pop_front();
            chk("rand out order", out_data, exp_d);
          end
        end
        if (iv && in_ready) q.push_back(id);
      end
      prev_hold = out_valid && !ordy && !f;
      prev_od   = out_data;
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised successor to the fixed ID/EX-style pipeline register. It is a single pipeline stage with a valid/ready handshake on both sides and a 2-entry skid buffer, so in_ready depends only on registered state and not on out_ready. The stage also supports synchronous flush and stall. It sits between any two core pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries a packed payload of configurable width.

Parameters:
DATA_W, 64, payload width in bits (>=1).
CLEAR_ON_FLUSH, 1, 1: payload registers are zeroed on flush; 0: only valid bits are cleared and payload holds its value.
RESET_DATA, '0, payload value loaded into both entries on reset (DATA_W bits).

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
flush_i  input  1  drop all held entries.
stall_i  input  1  freeze stage: no accept, no emit.
in_valid  input  1  upstream payload valid.
in_ready  output  1  stage can accept this cycle.
in_data  input  DATA_W  upstream payload.
out_valid  output  1  payload presented downstream.
out_ready  input  1  downstream accepts.
out_data  output  DATA_W  downstream payload.

Behaviour:
- Storage: main entry (main_v, main_d) drives out_data. Skid entry (skid_v, skid_d) holds overflow.
- States: EMPTY (!main_v), FULL (main_v & !skid_v), SKID (main_v & skid_v). The combination skid_v & !main_v is illegal and must never occur.
- in_ready = !skid_v & !stall_i & !rst. It is combinational only on stall_i and rst, never on out_ready.
- out_valid = main_v & !stall_i. out_data = main_d always, so it is visible even while stalled.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- EMPTY: in_fire -> FULL, main_d <= in_data. Latency is 1 cycle from in_fire to out_valid.
- FULL:
  - in_fire & out_fire -> FULL, main_d <= in_data.
  - in_fire & !out_fire -> SKID, skid_d <= in_data.
  - !in_fire & out_fire -> EMPTY.
- SKID: in_ready=0. out_fire -> FULL, main_d <= skid_d, skid_v <= 0.
- Sustained throughput is 1 transfer/cycle when out_ready is held high. Order is strictly FIFO; no loss and no duplication.
- Hold rule: while out_valid & !out_ready, out_data must not change. While stalled, main_d and skid_d must not change.
- Priority, highest first: rst > flush_i > stall_i > handshake.
- flush_i: next cycle main_v=0 and skid_v=0. If CLEAR_ON_FLUSH=1, main_d and skid_d are zeroed. Any in_fire or out_fire in the flush cycle is discarded. Upstream must not treat a transfer coincident with flush as delivered, since the flush also kills upstream.
- stall_i: state and data are held. in_ready=0 and out_valid=0, so no fire can occur.
- rst, synchronous:
  - next cycle main_v=0, skid_v=0, main_d=skid_d=RESET_DATA.
  - out_valid=0, out_data=RESET_DATA, in_ready=0 while rst is high and 1 on the first cycle after release if stall_i=0.
  - Reset mid-transfer discards all contents.
- Widths: no arithmetic on the payload; the payload is passed bit-exact.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_bubble_cnt[31:0].
  - perf_stall_cnt increments each cycle stall_i=1.
  - perf_bubble_cnt increments each cycle !stall_i & !main_v.
  - Both counters wrap at 2^32, are cleared by rst, and are unaffected by flush_i.
- Undefined: the ports and counters do not exist. Functional behaviour is identical either way.

Test Plan:
- Reset/idle:
  - Stimulus: rst=1 for 3 cycles, then release.
  - Required: out_valid=0, out_data=RESET_DATA, in_ready=0 during reset; in_ready=1 on cycle 1 after release.
- Streaming:
  - Stimulus: in_valid=1 with data 0x1..0x8 on consecutive cycles, out_ready=1.
  - Required: out_data 0x1..0x8 on consecutive cycles, each 1 cycle after its in_fire; in_ready stays 1.
- Skid fill:
  - Stimulus: out_ready=0, push 0xA then 0xB.
  - Required: in_ready=0 after 0xB is accepted and out_data=0xA held.
  - Stimulus: raise out_ready.
  - Required: 0xA, then 0xB emitted; in_ready=1 on the cycle after 0xA is accepted.
- Flush in SKID:
  - Stimulus: with 0xA/0xB held, pulse flush_i with in_valid=1 and data 0xC.
  - Required: next cycle out_valid=0, 0xC dropped, main_d=0 (CLEAR_ON_FLUSH=1).
- Stall:
  - Stimulus: stall_i=1 for 4 cycles while FULL with 0x55 and out_ready=1.
  - Required: out_valid=0 and in_ready=0 throughout; 0x55 emitted on the first cycle after stall_i drops. With PIPE_STAGE_PERF_EN, perf_stall_cnt=4.
- Random:
  - Stimulus: 10k cycles of random in_valid, out_ready, stall_i and rare flush_i.
  - Required: scoreboard shows in-order delivery with no loss or duplication between flushes; out_data stable whenever out_valid & !out_ready.
